alu_pipe: RTL and testbench

Parametrised, handshaked successor to the processor's combinational 8-bit ALU. Accepts one operation per cycle through a valid/ready input port and returns a registered result, zero flag and carry flag through a valid/ready output port. Adds an iterative unsigned multiplier with a double-width product. Sits between the decode/register-read stage and writeback; stalls upstream while a multiply is in progress or the output is back-pressured.

---
 rtl/alu_pipe.sv | 199 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with a registered result port and an iterative
// shift-add multiplier that produces a double-width product.
module alu_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zout,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);
    localparam int unsigned CNT_W   = SHAMT_W + 1;
    localparam int unsigned PROD_W  = 2 * WIDTH;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_NOT = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SBC = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_ROL = 4'b1011;
    localparam logic [3:0] OP_MUL = 4'b1100;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [PROD_W-1:0]  mcand;
    logic [PROD_W-1:0]  prod_acc;
    logic [PROD_W-1:0]  prod_next;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;

    logic               accept;
    logic               pop;
    logic               start_mul;
    logic               load_single;
    logic               mul_done;

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shl;
    logic [WIDTH:0]     shr;
    logic [PROD_W-1:0]  rot;
    logic [WIDTH-1:0]   alu_lo;
    logic               alu_c;
    logic               alu_z;

    // Handshake decode; in_ready depends only on state, out_valid and out_ready
    assign busy        = (state == ST_MUL);
    assign in_ready    = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept      = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    assign start_mul   = accept && (op == OP_MUL);
    assign load_single = accept && (op != OP_MUL);
    assign mul_done    = (state == ST_MUL) && (cnt == CNT_W'(WIDTH - 1));
    assign shamt       = b[SHAMT_W-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: leave IDLE on an accepted multiply, return after the last iteration
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_mul) state_next = ST_MUL;
            ST_MUL:  if (mul_done)  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Single-cycle datapath: logic, add/sub with carry, shifts and rotate
    always_comb begin
        sum    = '0;
        shl    = '0;
        shr    = '0;
        rot    = '0;
        alu_lo = '0;
        alu_c  = 1'b0;
        case (op)
            OP_AND: alu_lo = a & b;
            OP_OR:  alu_lo = a | b;
            OP_XOR: alu_lo = a ^ b;
            OP_NOT: alu_lo = ~a;
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                case (op)
                    OP_ADD:  sum = {1'b0, a} + {1'b0, b};
                    OP_ADC:  sum = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
                    OP_SUB:  sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                    default: sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(cin);
                endcase
                alu_lo = sum[WIDTH-1:0];
                alu_c  = sum[WIDTH];
            end
            OP_SLL: begin
                // Extra top bit catches the last bit shifted out
                shl    = {1'b0, a} << shamt;
                alu_lo = shl[WIDTH-1:0];
                alu_c  = shl[WIDTH];
            end
            OP_SRL: begin
                shr    = {a, 1'b0} >> shamt;
                alu_lo = shr[WIDTH:1];
                alu_c  = shr[0];
            end
            OP_SRA: begin
                shr    = $signed({a, 1'b0}) >>> shamt;
                alu_lo = shr[WIDTH:1];
                alu_c  = shr[0];
            end
            OP_ROL: begin
                rot    = {a, a} << shamt;
                alu_lo = rot[PROD_W-1:WIDTH];
                alu_c  = (shamt != '0) && rot[WIDTH];
            end
            default: begin
                alu_lo = '0;
                alu_c  = 1'b0;
            end
        endcase
        alu_z = (alu_lo == '0);
    end

    // One partial product per cycle
    assign prod_next = prod_acc + (mplier[0] ? mcand : '0);

    // Multiplier registers: load on acceptance, iterate while in MUL
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand    <= '0;
            mplier   <= '0;
            prod_acc <= '0;
            cnt      <= '0;
        end else if (start_mul) begin
            mcand    <= PROD_W'(a);
            mplier   <= b;
            prod_acc <= '0;
            cnt      <= '0;
        end else if (state == ST_MUL) begin
            mcand    <= mcand << 1;
            mplier   <= mplier >> 1;
            prod_acc <= prod_next;
            cnt      <= mul_done ? '0 : cnt + CNT_W'(1);
        end
    end

    // Output register: multiply completion, single-cycle load, or drain on pop
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            zout      <= 1'b0;
            cout      <= 1'b0;
        end else if (mul_done) begin
            out_valid <= 1'b1;
            result    <= prod_next[WIDTH-1:0];
            result_hi <= prod_next[PROD_W-1:WIDTH];
            zout      <= (prod_next == '0);
            cout      <= 1'b0;
        end else if (load_single) begin
            out_valid <= 1'b1;
            result    <= alu_lo;
            result_hi <= '0;
            zout      <= alu_z;
            cout      <= alu_c;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe against an
// arithmetic reference model and an in-order expected-result queue.
module tb_alu_pipe;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zout;
    logic         cout;
    logic         busy;

    int           checks = 0;
    int           errors = 0;
    bit           last_accept;
    logic [17:0]  exp_q[$];

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .zout      (zout),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: returns {hi[7:0], lo[7:0], zero, carry}
    function automatic logic [17:0] ref_alu(input logic [3:0] o, input int av,
                                            input int bv, input int ci);
        int lo, hi, c, n, sa, p;
        lo = 0; hi = 0; c = 0; sa = 0; p = 0;
        n = bv % 8;
        case (o)
            4'd0:  lo = av & bv;
            4'd1:  lo = av | bv;
            4'd2:  lo = av ^ bv;
            4'd3:  lo = ~av;
            4'd4:  begin lo = av + bv;      c = lo >> 8; end
            4'd5:  begin lo = av + bv + ci; c = lo >> 8; end
            4'd6:  begin lo = av - bv;      c = (av >= bv) ? 1 : 0; end
            4'd7:  begin lo = av - bv - (1 - ci); c = (av >= bv + 1 - ci) ? 1 : 0; end
            4'd8:  begin lo = av << n; c = (n != 0) ? ((av >> (8 - n)) & 1) : 0; end
            4'd9:  begin lo = av >> n; c = (n != 0) ? ((av >> (n - 1)) & 1) : 0; end
            4'd10: begin
                sa = (av >= 128) ? av - 256 : av;
                lo = sa >>> n;
                c  = (n != 0) ? ((av >> (n - 1)) & 1) : 0;
            end
            4'd11: begin lo = (av << n) | (av >> (8 - n)); c = (n != 0) ? (lo & 1) : 0; end
            4'd12: begin p = av * bv; lo = p; hi = p >> 8; end
            default: ;
        endcase
        lo = lo & 255;
        hi = hi & 255;
        return {8'(hi), 8'(lo), (lo == 0 && hi == 0), 1'(c)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: score handshakes that will fire at the coming edge, then advance
    task automatic cycle();
        logic [17:0] e;
        @(negedge clk);
        last_accept = 1'b0;
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_result",    result,    e[9:2]);
                    check("sb_result_hi", result_hi, e[17:10]);
                    check("sb_zout",      zout,      e[1]);
                    check("sb_cout",      cout,      e[0]);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_alu(op, int'(a), int'(b), int'(cin)));
                last_accept = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic c);
        op = o; a = x; b = y; cin = c; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (last_accept) break;
        end
        in_valid = 1'b0;
        if (!last_accept) check("issue_timeout", 0, 1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) cycle();
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        int idx;
        logic [7:0] bp_a[3];
        logic [7:0] bp_b[3];

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; a = '0; b = '0; cin = 1'b0;
        repeat (2) cycle();
        reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy",      busy,      0);
        check("rst_result",    result,    0);
        check("rst_result_hi", result_hi, 0);
        check("rst_zout",      zout,      0);
        check("rst_cout",      cout,      0);
        check("rst_in_ready",  in_ready,  1);

        // Directed single-cycle vectors
        issue(4'd4, 8'hFF, 8'h01, 1'b0);
        check("add_valid", out_valid, 1);
        check("add_res",   result,    8'h00);
        check("add_c",     cout,      1);
        check("add_z",     zout,      1);
        issue(4'd5, 8'h7F, 8'h00, 1'b1);
        check("adc_res", result, 8'h80);
        check("adc_c",   cout,   0);
        issue(4'd6, 8'h05, 8'h07, 1'b0);
        check("sub_res", result, 8'hFE);
        check("sub_c",   cout,   0);
        issue(4'd7, 8'h10, 8'h01, 1'b0);
        check("sbc_res", result, 8'h0E);
        check("sbc_c",   cout,   1);
        issue(4'd8, 8'h81, 8'h01, 1'b0);
        check("sll_res", result, 8'h02);
        check("sll_c",   cout,   1);
        issue(4'd10, 8'h80, 8'h03, 1'b0);
        check("sra_res", result, 8'hF0);
        check("sra_c",   cout,   0);
        issue(4'd11, 8'h81, 8'h01, 1'b0);
        check("rol_res", result, 8'h03);
        check("rol_c",   cout,   1);
        issue(4'd9, 8'hA5, 8'h00, 1'b0);
        check("srl0_res", result, 8'hA5);
        check("srl0_c",   cout,   0);
        issue(4'd14, 8'h12, 8'h34, 1'b1);
        check("rsv_res", result, 8'h00);
        check("rsv_z",   zout,   1);

        // Multiply latency and flags
        issue(4'd12, 8'hFF, 8'hFF, 1'b0);
        check("mul_busy0",  busy,      1);
        check("mul_ready0", in_ready,  0);
        check("mul_valid0", out_valid, 0);
        for (int k = 1; k < 8; k++) begin
            cycle();
            check("mul_busy",  busy,      1);
            check("mul_ready", in_ready,  0);
            check("mul_valid", out_valid, 0);
        end
        cycle();
        check("mul_done_valid", out_valid, 1);
        check("mul_done_busy",  busy,      0);
        check("mul_hi",         result_hi, 8'hFE);
        check("mul_lo",         result,    8'h01);
        check("mul_z",          zout,      0);
        issue(4'd12, 8'h00, 8'h5A, 1'b0);
        drain();

        // Backpressure: three ADDs while the consumer stalls
        bp_a[0] = 8'h01; bp_b[0] = 8'h02;
        bp_a[1] = 8'h10; bp_b[1] = 8'h20;
        bp_a[2] = 8'hF0; bp_b[2] = 8'h20;
        out_ready = 1'b0;
        issue(4'd4, bp_a[0], bp_b[0], 1'b0);
        check("bp_first", result, 8'h03);
        op = 4'd4; a = bp_a[1]; b = bp_b[1]; cin = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("bp_accept", last_accept, 0);
            check("bp_ready",  in_ready,    0);
            check("bp_hold",   result,      8'h03);
            check("bp_valid",  out_valid,   1);
        end
        out_ready = 1'b1;
        idx = 1; n = 0;
        while (idx < 3 && n < 20) begin
            a = bp_a[idx]; b = bp_b[idx];
            cycle();
            n++;
            if (last_accept) idx++;
        end
        in_valid = 1'b0;
        check("bp_tput", n, 2);
        drain();

        // Reset during the fourth multiply iteration
        issue(4'd12, 8'h33, 8'h44, 1'b0);
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        exp_q.delete();
        check("mrst_valid", out_valid, 0);
        check("mrst_busy",  busy,      0);
        check("mrst_ready", in_ready,  1);
        issue(4'd0, 8'hF0, 8'h3C, 1'b0);
        check("mrst_and_valid", out_valid, 1);
        check("mrst_and_res",   result,    8'h30);
        drain();

        // Randomized traffic with random backpressure
        for (int k = 0; k < 600; k++) begin
            in_valid  = ($urandom_range(3) != 0);
            op        = 4'($urandom_range(15));
            a         = 8'($urandom);
            b         = 8'($urandom);
            cin       = 1'($urandom_range(1));
            out_ready = ($urandom_range(3) != 0);
            cycle();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
